mem_port_arbiter: RTL and testbench

- Shares one single-ported memory between the core's instruction-fetch port and its load/store port, so the pipeline can run on a unified memory.
- Sits between the core's inst_*/data_* pins and the memory.
- Sequences each access with a req/ack handshake and raises a stall to the core while any access is outstanding.
- Data accesses have priority, with an anti-starvation rule for fetch. A wait-timeout flags a dead memory.

---
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the core's
// instruction-fetch port and its load/store port. Each access is a req/ack
// handshake with the memory. Data normally wins arbitration, but after
// DATA_STREAK_MAX consecutive data grants with a fetch waiting, the fetch goes
// next. A wait timeout aborts an access to a dead memory and sets a sticky error.
module mem_port_arbiter #(
    parameter int WORD_BITWIDTH   = 32,
    parameter int TIMEOUT_CYCLES  = 15,
    parameter int DATA_STREAK_MAX = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inst_ce_i,
    input  logic [WORD_BITWIDTH-1:0] inst_addr_i,
    output logic [WORD_BITWIDTH-1:0] inst_o,
    output logic                     inst_ready_o,
    input  logic                     data_ce_i,
    input  logic                     data_we_i,
    input  logic [WORD_BITWIDTH-1:0] data_addr_i,
    input  logic [WORD_BITWIDTH-1:0] data_wdata_i,
    output logic [WORD_BITWIDTH-1:0] data_rdata_o,
    output logic                     data_ready_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [WORD_BITWIDTH-1:0] mem_addr_o,
    output logic [WORD_BITWIDTH-1:0] mem_wdata_o,
    input  logic [WORD_BITWIDTH-1:0] mem_rdata_i,
    input  logic                     mem_ack_i,
    output logic                     stall_o,
    output logic                     err_o
);

    // Timeout counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit
    // so the design still elaborates when the timeout is disabled.
    localparam int TO_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int STREAK_W = (DATA_STREAK_MAX > 0) ? $clog2(DATA_STREAK_MAX + 1) : 1;

    localparam logic [TO_W-1:0]     TO_LAST    = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        D_WAIT = 2'd1,
        I_WAIT = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                   state_q;
    logic [STREAK_W-1:0]      streak_q;
    logic [STREAK_W-1:0]      streak_d;
    logic [TO_W-1:0]          to_cnt_q;

    logic [WORD_BITWIDTH-1:0] inst_q;
    logic                     inst_ready_q;
    logic [WORD_BITWIDTH-1:0] data_rdata_q;
    logic                     data_ready_q;
    logic                     mem_req_q;
    logic                     mem_we_q;
    logic [WORD_BITWIDTH-1:0] mem_addr_q;
    logic [WORD_BITWIDTH-1:0] mem_wdata_q;
    logic                     err_q;

    logic                     grant_data;
    logic                     grant_inst;
    logic                     to_expire;

    // Data wins unless a waiting fetch has already been passed over too often.
    assign grant_data = data_ce_i && !(inst_ce_i && (streak_q == STREAK_MAX));
    assign grant_inst = !grant_data && inst_ce_i;
    assign to_expire  = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

    // Next streak value, applied only when a grant is actually made.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
        streak_d = '0;
        if (grant_data && inst_ce_i) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
        end
    end

    // Access sequencer: arbitration, handshake, timeout and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            streak_q     <= '0;
            to_cnt_q     <= '0;
            inst_q       <= '0;
            inst_ready_q <= 1'b0;
            data_rdata_q <= '0;
            data_ready_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees pre-edge values.
            case (state_q)
                IDLE: begin
                    if (grant_data) begin
                        mem_addr_q  <= data_addr_i;
                        mem_we_q    <= data_we_i;
                        mem_wdata_q <= data_wdata_i;
                        mem_req_q   <= 1'b1;
                        to_cnt_q    <= '0;
                        streak_q    <= streak_d;
                        state_q     <= D_WAIT;
                    end else if (grant_inst) begin
                        mem_addr_q <= inst_addr_i;
                        mem_we_q   <= 1'b0;
                        mem_req_q  <= 1'b1;
                        to_cnt_q   <= '0;
                        streak_q   <= streak_d;
                        state_q    <= I_WAIT;
                    end
                end

                D_WAIT, I_WAIT: begin
                    if (mem_ack_i) begin
                        // Ack beats a timeout landing on the same edge.
                        mem_req_q <= 1'b0;
                        if (state_q == D_WAIT) begin
                            data_rdata_q <= mem_we_q ? '0 : mem_rdata_i;
                            data_ready_q <= 1'b1;
                        end else begin
                            inst_q       <= mem_rdata_i;
                            inst_ready_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else if (to_expire) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        if (state_q == D_WAIT) begin
                            data_rdata_q <= '0;
                            data_ready_q <= 1'b1;
                        end else begin
                            inst_q       <= '0;
                            inst_ready_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                RESP: begin
                    // One-cycle pulse; no grant here so a still-held ce is not served twice.
                    inst_ready_q <= 1'b0;
                    data_ready_q <= 1'b0;
                    state_q      <= IDLE;
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign inst_o       = inst_q;
    assign inst_ready_o = inst_ready_q;
    assign data_rdata_o = data_rdata_q;
    assign data_ready_o = data_ready_q;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign err_o        = err_q;

    assign stall_o = (inst_ce_i & ~inst_ready_q) | (data_ce_i & ~data_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a scripted
// memory responder, a grant-order scoreboard and per-port response scoreboards.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_o;
    logic        inst_ready_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ready_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic        stall_o;
    logic        err_o;

    mem_port_arbiter #(
        .WORD_BITWIDTH  (32),
        .TIMEOUT_CYCLES (15),
        .DATA_STREAK_MAX(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_ce_i   (inst_ce_i),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_o),
        .inst_ready_o(inst_ready_o),
        .data_ce_i   (data_ce_i),
        .data_we_i   (data_we_i),
        .data_addr_i (data_addr_i),
        .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o),
        .data_ready_o(data_ready_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .stall_o     (stall_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        bit          chk_wdata;
    } grant_t;

    grant_t      grant_q[$];
    logic [31:0] inst_exp_q[$];
    logic [31:0] data_exp_q[$];
    logic [31:0] pend_load_q[$];
    logic [31:0] pend_fetch_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int n_inst_pulse = 0;
    int n_data_pulse = 0;
    int ack_wait = 1;       // wait cycle on which the memory acks; 0 = never
    int resp_wait = 0;
    logic prev_req = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] addr);
        if (addr == 32'h0000_0100) return 32'h00A0_0093;
        return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input bit chk_wdata);
        grant_t g;
        g.addr = addr; g.we = we; g.wdata = wdata; g.chk_wdata = chk_wdata;
        grant_q.push_back(g);
    endtask

    task automatic issue_data(input logic [31:0] addr, input logic we,
                              input logic [31:0] wdata, input logic [31:0] exp);
        data_ce_i    = 1'b1;
        data_we_i    = we;
        data_addr_i  = addr;
        data_wdata_i = wdata;
        data_exp_q.push_back(exp);
    endtask

    task automatic issue_load(input logic [31:0] addr);
        issue_data(addr, 1'b0, $urandom, rd_word(addr));
    endtask

    task automatic issue_fetch(input logic [31:0] addr);
        inst_ce_i   = 1'b1;
        inst_addr_i = addr;
        inst_exp_q.push_back(rd_word(addr));
    endtask

    // Keep requesters alive until every queued access is done, then drain RESP.
    task automatic serve(input int budget);
        int n = 0;
        while ((inst_ce_i || data_ce_i) && n < budget) begin
            tick();
            n++;
            if (data_ready_o) begin
                if (pend_load_q.size() != 0) issue_load(pend_load_q.pop_front());
                else data_ce_i = 1'b0;
            end
            if (inst_ready_o) begin
                if (pend_fetch_q.size() != 0) issue_fetch(pend_fetch_q.pop_front());
                else inst_ce_i = 1'b0;
            end
        end
        check("serve_in_budget", 32'(inst_ce_i | data_ce_i), 32'd0);
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        tick();
        tick();
    endtask

    // Memory model: ack on the ack_wait-th cycle of an outstanding request.
    always @(negedge clk) begin
        if (mem_req_o) begin
            resp_wait = resp_wait + 1;
            if (ack_wait != 0 && resp_wait == ack_wait) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = rd_word(mem_addr_o);
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hBAD0_BAD0;
            end
        end else begin
            resp_wait   = 0;
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
        end
    end

    // Grant scoreboard: each new request must match the next expected grant.
    always @(negedge clk) begin
        grant_t g;
        if (mem_req_o && !prev_req) begin
            check("grant_expected", 32'(grant_q.size() != 0), 32'd1);
            if (grant_q.size() != 0) begin
                g = grant_q.pop_front();
                check("grant_addr", mem_addr_o, g.addr);
                check("grant_we", 32'(mem_we_o), 32'(g.we));
                if (g.chk_wdata) check("grant_wdata", mem_wdata_o, g.wdata);
            end
        end
        prev_req <= mem_req_o;
    end

    // Response scoreboards: every ready pulse pops and compares one result.
    always @(negedge clk) begin
        if (inst_ready_o) begin
            n_inst_pulse++;
            check("inst_expected", 32'(inst_exp_q.size() != 0), 32'd1);
            if (inst_exp_q.size() != 0) check("inst_data", inst_o, inst_exp_q.pop_front());
        end
        if (data_ready_o) begin
            n_data_pulse++;
            check("data_expected", 32'(data_exp_q.size() != 0), 32'd1);
            if (data_exp_q.size() != 0) check("data_rdata", data_rdata_o, data_exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ip;
        int dp;
        rst          = 1'b0;
        inst_ce_i    = 1'b0;
        inst_addr_i  = '0;
        data_ce_i    = 1'b0;
        data_we_i    = 1'b0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_ack_i    = 1'b0;
        mem_rdata_i  = '0;
        #1 rst = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_mem_req", 32'(mem_req_o), 32'd0);
        check("rst_mem_addr", mem_addr_o, 32'd0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_data_rdata", data_rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        rst = 1'b0;
        tick();

        // Fetch only, ack on the 2nd wait cycle.
        ack_wait = 2;
        push_grant(32'h100, 1'b0, '0, 1'b0);
        issue_fetch(32'h100);
        tick();
        check("f_req_w1", 32'(mem_req_o), 32'd1);
        check("f_we", 32'(mem_we_o), 32'd0);
        check("f_stall_wait", 32'(stall_o), 32'd1);
        tick();
        check("f_req_w2", 32'(mem_req_o), 32'd1);
        check("f_ready_early", 32'(inst_ready_o), 32'd0);
        tick();
        check("f_req_drop", 32'(mem_req_o), 32'd0);
        check("f_ready", 32'(inst_ready_o), 32'd1);
        check("f_inst", inst_o, 32'h00A0_0093);
        check("f_stall_resp", 32'(stall_o), 32'd0);
        inst_ce_i = 1'b0;
        tick();
        check("f_ready_clear", 32'(inst_ready_o), 32'd0);
        check("f_inst_hold", inst_o, 32'h00A0_0093);
        tick();

        // Simultaneous fetch and store: store first, one pulse each.
        ack_wait = 1;
        ip = n_inst_pulse;
        dp = n_data_pulse;
        push_grant(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b1);
        push_grant(32'h104, 1'b0, '0, 1'b0);
        issue_data(32'h200, 1'b1, 32'hDEAD_BEEF, 32'h0);
        issue_fetch(32'h104);
        serve(60);
        check("sim_inst_pulses", 32'(n_inst_pulse - ip), 32'd1);
        check("sim_data_pulses", 32'(n_data_pulse - dp), 32'd1);

        // Starvation guard: D, D, I, D, D, I.
        push_grant(32'h300, 1'b0, '0, 1'b0);
        push_grant(32'h304, 1'b0, '0, 1'b0);
        push_grant(32'h400, 1'b0, '0, 1'b0);
        push_grant(32'h308, 1'b0, '0, 1'b0);
        push_grant(32'h30C, 1'b0, '0, 1'b0);
        push_grant(32'h404, 1'b0, '0, 1'b0);
        pend_load_q  = '{32'h304, 32'h308, 32'h30C};
        pend_fetch_q = '{32'h404};
        issue_load(32'h300);
        issue_fetch(32'h400);
        serve(200);

        // Timeout on a load that is never acked.
        ack_wait = 0;
        push_grant(32'h500, 1'b0, '0, 1'b0);
        issue_data(32'h500, 1'b0, 32'h1234_5678, 32'h0);
        tick();
        n = 0;
        while (mem_req_o && n < 40) begin
            n++;
            tick();
        end
        check("to_req_cycles", 32'(n), 32'd15);
        check("to_ready", 32'(data_ready_o), 32'd1);
        check("to_rdata", data_rdata_o, 32'd0);
        check("to_err", 32'(err_o), 32'd1);
        data_ce_i = 1'b0;
        tick();
        tick();

        // A good load afterwards leaves the error flag set.
        ack_wait = 1;
        push_grant(32'h504, 1'b0, '0, 1'b0);
        issue_load(32'h504);
        serve(60);
        check("err_sticky", 32'(err_o), 32'd1);

        // Reset mid-access: everything drops asynchronously, no ready pulse.
        ack_wait = 0;
        ip = n_inst_pulse;
        dp = n_data_pulse;
        push_grant(32'h700, 1'b1, 32'hCAFE_F00D, 1'b1);
        data_ce_i    = 1'b1;
        data_we_i    = 1'b1;
        data_addr_i  = 32'h700;
        data_wdata_i = 32'hCAFE_F00D;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("ra_mem_req", 32'(mem_req_o), 32'd0);
        check("ra_mem_we", 32'(mem_we_o), 32'd0);
        check("ra_mem_addr", mem_addr_o, 32'd0);
        check("ra_mem_wdata", mem_wdata_o, 32'd0);
        check("ra_inst_o", inst_o, 32'd0);
        check("ra_data_rdata", data_rdata_o, 32'd0);
        check("ra_err", 32'(err_o), 32'd0);
        data_ce_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("ra_no_data_pulse", 32'(n_data_pulse - dp), 32'd0);
        ack_wait = 2;
        push_grant(32'h108, 1'b0, '0, 1'b0);
        issue_fetch(32'h108);
        serve(60);
        check("ra_fetch_pulse", 32'(n_inst_pulse - ip), 32'd1);

        // Ack on the same edge the timeout would fire: ack wins.
        ack_wait = 15;
        push_grant(32'h600, 1'b0, '0, 1'b0);
        issue_load(32'h600);
        tick();
        n = 0;
        while (mem_req_o && n < 40) begin
            n++;
            tick();
        end
        check("col_req_cycles", 32'(n), 32'd15);
        check("col_ready", 32'(data_ready_o), 32'd1);
        check("col_err", 32'(err_o), 32'd0);
        data_ce_i = 1'b0;
        tick();
        tick();

        check("grant_q_empty", 32'(grant_q.size()), 32'd0);
        check("inst_q_empty", 32'(inst_exp_q.size()), 32'd0);
        check("data_q_empty", 32'(data_exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
